// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for the data-memory arbiter.
// The master issues req plus a command and the arbiter answers with gnt, then rvalid/rdata/err.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, funct3, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory with combinational reads.
// One access is in flight at a time, and illegal requests are answered without touching memory.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter bit          FIX_PRIO  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic          mem_we,
  output logic          mem_re,
  output logic [2:0]    mem_funct3,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_BYTES);

  state_t      state;
  logic        rr_ptr;
  logic        owner;
  logic        cmd_we;
  logic [2:0]  cmd_funct3;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        we_reg;
  logic        re_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic [1:0]  rvalid_reg;

  logic        any_req;
  logic        winner;
  logic        sel_we;
  logic [2:0]  sel_funct3;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        f3_ok;
  logic        align_ok;
  logic        legal;

  always_comb begin
    any_req = m0.req | m1.req;
    // With a single requester it wins outright; rr_ptr only breaks ties.
    if (m0.req && m1.req) winner = FIX_PRIO ? 1'b0 : rr_ptr;
    else                  winner = m1.req;
    sel_we     = winner ? m1.we     : m0.we;
    sel_funct3 = winner ? m1.funct3 : m0.funct3;
    sel_addr   = winner ? m1.addr   : m0.addr;
    sel_wdata  = winner ? m1.wdata  : m0.wdata;
  end

  always_comb begin
    f3_ok    = 1'b1;
    align_ok = 1'b1;
    case (sel_funct3)
      3'b000:  align_ok = 1'b1;
      3'b001:  align_ok = ~sel_addr[0];
      3'b010:  align_ok = (sel_addr[1:0] == 2'b00);
      3'b100:  f3_ok    = ~sel_we;
      3'b101: begin
        f3_ok    = ~sel_we;
        align_ok = ~sel_addr[0];
      end
      default: f3_ok    = 1'b0;
    endcase
    legal = f3_ok && align_ok && ({1'b0, sel_addr} < ADDR_LIMIT);
  end

  assign m0.gnt = (state == IDLE) && m0.req && !winner;
  assign m1.gnt = (state == IDLE) && m1.req && winner;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_funct3 <= 3'b000;
      cmd_addr   <= 32'h0;
      cmd_wdata  <= 32'h0;
      we_reg     <= 1'b0;
      re_reg     <= 1'b0;
      rdata_reg  <= 32'h0;
      err_reg    <= 1'b0;
      rvalid_reg <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= winner;
            rr_ptr     <= ~winner;
            cmd_we     <= sel_we;
            cmd_funct3 <= sel_funct3;
            cmd_addr   <= sel_addr;
            cmd_wdata  <= sel_wdata;
            if (legal) begin
              state  <= ACCESS;
              we_reg <= sel_we;
              re_reg <= ~sel_we;
            end else begin
              state      <= RESP;
              err_reg    <= 1'b1;
              rdata_reg  <= 32'h0;
              rvalid_reg <= winner ? 2'b10 : 2'b01;
            end
          end
        end
        ACCESS: begin
          state      <= RESP;
          we_reg     <= 1'b0;
          re_reg     <= 1'b0;
          err_reg    <= 1'b0;
          rdata_reg  <= cmd_we ? 32'h0 : mem_rdata;
          rvalid_reg <= owner ? 2'b10 : 2'b01;
        end
        RESP: begin
          state      <= IDLE;
          rvalid_reg <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with reset keeps an interrupted store from landing in memory on the reset edge.
  assign mem_we     = we_reg & ~reset;
  assign mem_re     = re_reg & ~reset;
  assign mem_funct3 = cmd_funct3;
  assign mem_addr   = cmd_addr;
  assign mem_wdata  = cmd_wdata;

  assign m0.rvalid = rvalid_reg[0];
  assign m0.rdata  = rdata_reg;
  assign m0.err    = err_reg;
  assign m1.rvalid = rvalid_reg[1];
  assign m1.rdata  = rdata_reg;
  assign m1.err    = err_reg;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array memory model.
// A second instance with FIX_PRIO=1 checks fixed priority.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 65536;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if if0();
  dmem_arbiter_if if1();
  dmem_arbiter_if fx0();
  dmem_arbiter_if fx1();

  logic        mem_we, mem_re;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        fx_mem_we, fx_mem_re;
  logic [2:0]  fx_mem_funct3;
  logic [31:0] fx_mem_addr, fx_mem_wdata;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .FIX_PRIO(1'b0)) u_dut (
    .clk(clk), .reset(reset), .m0(if0), .m1(if1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .FIX_PRIO(1'b1)) u_fix (
    .clk(clk), .reset(reset), .m0(fx0), .m1(fx1),
    .mem_we(fx_mem_we), .mem_re(fx_mem_re), .mem_funct3(fx_mem_funct3),
    .mem_addr(fx_mem_addr), .mem_wdata(fx_mem_wdata), .mem_rdata(32'h0)
  );

  // Memory model: combinational extended read, synchronous byte-lane write.
  logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};
  logic [7:0] rb0, rb1, rb2, rb3;
  always_comb begin
    rb0 = mem[mem_addr[15:0]];
    rb1 = mem[mem_addr[15:0] + 16'd1];
    rb2 = mem[mem_addr[15:0] + 16'd2];
    rb3 = mem[mem_addr[15:0] + 16'd3];
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{rb0[7]}}, rb0};
      3'b001:  mem_rdata = {{16{rb1[7]}}, rb1, rb0};
      3'b100:  mem_rdata = {24'h0, rb0};
      3'b101:  mem_rdata = {16'h0, rb1, rb0};
      default: mem_rdata = {rb3, rb2, rb1, rb0};
    endcase
  end
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[15:0]] <= mem_wdata[7:0];
      if (mem_funct3 != 3'b000) mem[mem_addr[15:0] + 16'd1] <= mem_wdata[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[mem_addr[15:0] + 16'd2] <= mem_wdata[23:16];
        mem[mem_addr[15:0] + 16'd3] <= mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          gcyc;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   glog[$];
  int   we_log[$];
  int   re_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   g0_cnt = 0;
  exp_t me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Response monitor: pops the owner's queue whenever rvalid is seen.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (if0.rvalid && if1.rvalid) flag("both_rvalid", "rvalid=1 on both ports, required on one");
      if (if0.gnt && if1.gnt) flag("both_gnt", "gnt=1 on both ports, required on one");
      if (mem_we && mem_re) flag("we_and_re", "mem_we and mem_re both 1");
      if (if0.gnt) begin glog.push_back(0); g0_cnt++; end
      if (if1.gnt) glog.push_back(1);
      if (mem_we) we_log.push_back(cyc);
      if (mem_re) re_log.push_back(cyc);
      if (if0.rvalid) begin
        if (q0.size() == 0) flag("unexp_rvalid0", "rvalid=1 on port 0, required 0 (nothing outstanding)");
        else begin
          me = q0.pop_front();
          check("p0_rdata", if0.rdata, me.rdata);
          check("p0_err", 32'(if0.err), 32'(me.err));
          check("p0_latency", 32'(cyc - me.gcyc), 32'(me.lat));
        end
      end
      if (if1.rvalid) begin
        if (q1.size() == 0) flag("unexp_rvalid1", "rvalid=1 on port 1, required 0 (nothing outstanding)");
        else begin
          me = q1.pop_front();
          check("p1_rdata", if1.rdata, me.rdata);
          check("p1_err", 32'(if1.err), 32'(me.err));
          check("p1_latency", 32'(cyc - me.gcyc), 32'(me.lat));
        end
      end
    end
  end

  task automatic drive(input int p, input logic rq, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      if0.req = rq; if0.we = we; if0.funct3 = f3; if0.addr = a; if0.wdata = d;
    end else begin
      if1.req = rq; if1.we = we; if1.funct3 = f3; if1.addr = a; if1.wdata = d;
    end
  endtask

  function automatic logic get_gnt(input int p);
    return (p == 0) ? if0.gnt : if1.gnt;
  endfunction

  // Call at a falling edge; returns at the falling edge after the grant with req dropped.
  task automatic do_req(input int p, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd,
                        input bit push, output int gcyc, output int waited);
    exp_t e;
    waited = 0;
    gcyc = -1;
    drive(p, 1'b1, we, f3, a, d);
    #1;
    while (!get_gnt(p)) begin
      if (waited >= 40) begin
        flag("gnt_timeout", $sformatf("port %0d got no gnt in %0d cycles, required a grant", p, waited));
        drive(p, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        return;
      end
      @(negedge clk);
      #1;
      waited++;
    end
    gcyc = cyc;
    if (push) begin
      e.err = exp_err; e.rdata = exp_rd; e.gcyc = cyc; e.lat = exp_err ? 1 : 2;
      if (p == 0) q0.push_back(e); else q1.push_back(e);
    end
    $display("grant port %0d we=%0b f3=%03b addr=%h wdata=%h at cycle %0d", p, we, f3, a, d, cyc);
    @(negedge clk);
    drive(p, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic xact(input int p, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
    int g, w;
    do_req(p, we, f3, a, d, exp_err, exp_rd, 1'b1, g, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, w, ws, rs, gs, g0s, fg0, fg1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    fx0.req = 1'b0; fx0.we = 1'b0; fx0.funct3 = 3'b000; fx0.addr = 32'h0; fx0.wdata = 32'h0;
    fx1.req = 1'b0; fx1.we = 1'b0; fx1.funct3 = 3'b000; fx1.addr = 32'h0; fx1.wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt0", 32'(if0.gnt), 32'h0);
    check("rst_rvalid", 32'({if1.rvalid, if0.rvalid}), 32'h0);
    check("rst_mem_we_re", 32'({mem_we, mem_re}), 32'h0);
    check("rst_rdata", if0.rdata, 32'h0);
    check("rst_err", 32'(if0.err), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Byte store from the loader, then extended loads from the core.
    xact(1, 1'b1, 3'b000, 32'h103, 32'h0000_0080, 1'b0, 32'h0);
    xact(0, 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'hFFFF_FF80);
    xact(0, 1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 32'h0000_0080);
    xact(0, 1'b0, 3'b101, 32'h102, 32'h0, 1'b0, 32'h0000_8000);

    // Word store: mem_we only in the cycle after gnt.
    ws = we_log.size();
    do_req(0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, g, w);
    repeat (2) @(negedge clk);
    check("sw_we_count", 32'(we_log.size() - ws), 32'h1);
    if (we_log.size() > ws) check("sw_we_cycle", 32'(we_log[ws]), 32'(g + 1));
    xact(0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF);
    xact(1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF);

    // Both ports requesting back to back alternate.
    gs = glog.size();
    fork
      begin for (int k = 0; k < 3; k++) xact(0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF); end
      begin for (int k = 0; k < 3; k++) xact(1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF); end
    join
    repeat (2) @(negedge clk);
    check("rr_grant_count", 32'(glog.size() - gs), 32'd6);
    for (int k = 0; k < 6; k++)
      if (glog.size() > gs + k) check($sformatf("rr_order_%0d", k), 32'(glog[gs + k]), 32'(k % 2));

    // Illegal requests never reach memory.
    ws = we_log.size();
    rs = re_log.size();
    xact(0, 1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 32'h0);
    xact(1, 1'b1, 3'b001, 32'h101, 32'hFFFF_FFFF, 1'b1, 32'h0);
    xact(0, 1'b0, 3'b000, 32'h0001_0000, 32'h0, 1'b1, 32'h0);
    xact(1, 1'b1, 3'b100, 32'h100, 32'h0, 1'b1, 32'h0);
    repeat (2) @(negedge clk);
    check("illegal_no_we", 32'(we_log.size() - ws), 32'h0);
    check("illegal_no_re", 32'(re_log.size() - rs), 32'h0);
    xact(1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF);
    xact(0, 1'b0, 3'b010, 32'h0000_FFFC, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    // Reset during ACCESS of a store drops it entirely.
    ws = we_log.size();
    do_req(0, 1'b1, 3'b010, 32'h200, 32'h1234_5678, 1'b0, 32'h0, 1'b0, g, w);
    reset = 1'b1;
    #1;
    check("reset_mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    do_req(0, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 32'h0, 1'b1, g, w);
    check("post_reset_idle_wait", 32'(w), 32'h0);
    check("reset_no_write", 32'(we_log.size() - ws), 32'h0);
    repeat (2) @(negedge clk);

    // Withdrawn request while the other port owns the bus.
    g0s = g0_cnt;
    fork
      xact(1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF);
      begin
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      end
    join
    repeat (4) @(negedge clk);
    check("withdraw_no_gnt", 32'(g0_cnt - g0s), 32'h0);

    // Fixed priority instance: port 0 wins every IDLE.
    fg0 = 0;
    fg1 = 0;
    fx0.req = 1'b1; fx0.funct3 = 3'b010;
    fx1.req = 1'b1; fx1.funct3 = 3'b010;
    repeat (12) begin
      #1;
      if (fx0.gnt) fg0++;
      if (fx1.gnt) fg1++;
      @(negedge clk);
    end
    fx0.req = 1'b0;
    fx1.req = 1'b0;
    check("fix_prio_p0_grants", 32'(fg0), 32'd4);
    check("fix_prio_p1_grants", 32'(fg1), 32'd0);

    repeat (4) @(negedge clk);
    check("drain_q0", 32'(q0.size()), 32'h0);
    check("drain_q1", 32'(q1.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
